// File: rtl/rf_write_arbiter_if.sv
// Write-source and register-file port bundle for rf_write_arbiter.
// master = writeback sources and counter control; slave = the arbiter.
interface rf_write_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
);
  logic                     a_valid;
  logic                     a_ready;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]    b_data;
  logic                     rf_we;
  logic [ADDRESS_WIDTH-1:0] rf_A3;
  logic [DATA_WIDTH-1:0]    rf_WD;
  logic [CNT_WIDTH-1:0]     conflict_cnt;
  logic                     cnt_clr;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, cnt_clr,
    input  a_ready, b_ready, rf_we, rf_A3, rf_WD, conflict_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, cnt_clr,
    output a_ready, b_ready, rf_we, rf_A3, rf_WD, conflict_cnt
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback sources.
// Ready is combinational from valid; the granted write appears on rf_* one cycle later.
module rf_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               res,
  rf_write_arbiter_if.slave  bus
);
  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

  src_t                     last;
  src_t                     last_nxt;
  logic                     grant_a;
  logic                     grant_b;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] a3_q;
  logic [DATA_WIDTH-1:0]    wd_q;
  logic [CNT_WIDTH-1:0]     cnt_q;

  // The source that did not win last time gets priority when both are valid.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    last_nxt = last;
    if (!res) begin
      if (bus.a_valid && (!bus.b_valid || last == SRC_B)) begin
        grant_a  = 1'b1;
        last_nxt = SRC_A;
      end else if (bus.b_valid) begin
        grant_b  = 1'b1;
        last_nxt = SRC_B;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      last <= SRC_B;
    end else begin
      last <= last_nxt;
    end
  end

  // Register-0 writes complete the handshake but never raise the write enable.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
    end else if (grant_a) begin
      we_q <= |bus.a_addr;
      a3_q <= bus.a_addr;
      wd_q <= bus.a_data;
    end else if (grant_b) begin
      we_q <= |bus.b_addr;
      a3_q <= bus.b_addr;
      wd_q <= bus.b_data;
    end else begin
      we_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (bus.a_valid && bus.b_valid && cnt_q != {CNT_WIDTH{1'b1}}) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.a_ready      = grant_a;
  assign bus.b_ready      = grant_b;
  assign bus.rf_we        = we_q;
  assign bus.rf_A3        = a3_q;
  assign bus.rf_WD        = wd_q;
  assign bus.conflict_cnt = cnt_q;
endmodule
